// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types and constants
package mips_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC source selection for the fetch unit
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  fetch_state_t     state,
  input  logic             req,
  input  logic             ack,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] jump_target,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] pending,
  input  logic [WIDTH-1:0] pc_cur,
  input  logic [WIDTH-1:0] pc_plus4,
  output logic             redirect,
  output logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc_next
);

  // Jump wins over branch; a redirect that hits an in-flight request is
  // deferred (PC holds) until the memory drains, otherwise it applies now.
  always_comb begin
    redirect = jump || branch_taken;
    target   = jump ? jump_target : branch_target;
    pc_next  = pc_cur;
    case (state)
      FETCH: begin
        if (redirect) begin
          if (!(req && !ack)) pc_next = target;
        end else if (ack) begin
          pc_next = pc_plus4;
        end
      end
      DRAIN: begin
        if (ack) pc_next = redirect ? target : pending;
      end
      default: pc_next = pc_cur;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, fetch FSM and IF/ID instruction slot
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] pc_out,
  input  logic [WIDTH-1:0] pc_plus4_in,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid
);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] drain_addr;
  logic [WIDTH-1:0] target;
  logic             redirect;
  logic             ack;
  logic             consume;

  assign pc_out  = pc_reg;
  assign ack     = imem_req && imem_ack;
  assign consume = instr_valid && !stall;

  pc_next_sel #(
    .WIDTH(WIDTH)
  ) u_next_sel (
    .state        (state),
    .req          (imem_req),
    .ack          (ack),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jump_target  (jump_target),
    .branch_target(branch_target),
    .pending      (pending),
    .pc_cur       (pc_reg),
    .pc_plus4     (pc_plus4_in),
    .redirect     (redirect),
    .target       (target),
    .pc_next      (pc_next)
  );

  // Request/address outputs; reset kills the request without waiting for a clock.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg;
    case (state)
      FETCH: imem_req = rst_n && !(instr_valid && stall);
      DRAIN: begin
        imem_req  = rst_n;
        imem_addr = drain_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Next state: a redirect against an unacknowledged request must drain it first.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (redirect && imem_req && !ack) state_next = DRAIN;
      DRAIN:   if (ack) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // PC, deferred redirect target and the address frozen while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg     <= RESET_PC;
      pending    <= '0;
      drain_addr <= '0;
    end else begin
      pc_reg <= pc_next;
      if (redirect && state_next == DRAIN) pending <= target;
      if (state == FETCH && state_next == DRAIN) drain_addr <= pc_reg;
    end
  end

  // IF/ID slot: squash on redirect, load on a FETCH ack, empty when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out   <= WIDTH'(NOP_INSTR);
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (state == FETCH && ack) begin
      instr_out   <= imem_rdata;
      instr_pc    <= pc_reg;
      instr_valid <= 1'b1;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cnt = 0;

  pc_fetch_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_out       (pc_out),
    .pc_plus4_in  (pc_plus4_in),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid)
  );

  always #5 clk = ~clk;

  assign pc_plus4_in = pc_out + 32'd4;
  assign imem_rdata  = imem_addr ^ 32'hDEAD_0000;
  assign imem_ack    = imem_req && ((lat == 1) || (cnt == lat - 1));

  always @(posedge clk) begin
    if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                       cnt <= 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = '0; branch_target = '0;
    #2;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc got %h exp 0", instr_pc); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out got %h exp 0", instr_out); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got %b exp 1", imem_req); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc_out !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc got %h exp %h", pc_out, 32'(i * 4)); end
      checks++; if (instr_pc !== 32'((i - 1) * 4)) begin errors++; $display("FAIL seq_instr_pc got %h exp %h", instr_pc, 32'((i - 1) * 4)); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b exp 1", instr_valid); end
    end
    checks++; if (instr_out !== 32'hDEAD_0008) begin errors++; $display("FAIL seq_instr_out got %h exp %h", instr_out, 32'hDEAD_0008); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instr_pc !== 32'h8) begin errors++; $display("FAIL stall_instr_pc got %h exp 8", instr_pc); end
      checks++; if (instr_out !== 32'hDEAD_0008) begin errors++; $display("FAIL stall_instr_out got %h exp DEAD0008", instr_out); end
      checks++; if (pc_out !== 32'hC) begin errors++; $display("FAIL stall_pc got %h exp c", pc_out); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_held got %b exp 0", imem_req); end
    end
    stall = 1'b0;
    step();
    checks++; if (instr_pc !== 32'hC) begin errors++; $display("FAIL unstall_instr_pc got %h exp c", instr_pc); end
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL unstall_pc got %h exp 10", pc_out); end
  endtask

  task automatic test_branch();
    checks++; if (imem_ack !== 1'b1) begin errors++; $display("FAIL branch_pre_ack got %b exp 1", imem_ack); end
    branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch_squash got %b exp 0", instr_valid); end
    checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL branch_pc got %h exp 40", pc_out); end
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL branch_next_valid got %b exp 1", instr_valid); end
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL branch_next_instr_pc got %h exp 40", instr_pc); end
    checks++; if (instr_out !== 32'hDEAD_0040) begin errors++; $display("FAIL branch_next_instr_out got %h exp DEAD0040", instr_out); end
  endtask

  task automatic test_jump_drain();
    int n;
    jump = 1'b1; jump_target = 32'h20;
    step();
    jump = 1'b0;
    checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL jd_setup_pc got %h exp 20", pc_out); end
    lat = 3;
    #1;
    checks++; if (imem_ack !== 1'b0) begin errors++; $display("FAIL jd_first_ack got %b exp 0", imem_ack); end
    step();
    jump = 1'b1; jump_target = 32'h100;
    #1;
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL jd_addr_pre got %h exp 20", imem_addr); end
    step();
    jump = 1'b0;
    #1;
    checks++; if (dut.state !== DRAIN) begin errors++; $display("FAIL jd_state got %0d exp DRAIN", dut.state); end
    checks++; if (imem_addr !== 32'h20) begin errors++; $display("FAIL jd_addr_drain got %h exp 20", imem_addr); end
    checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL jd_pc_hold got %h exp 20", pc_out); end
    checks++; if (imem_ack !== 1'b1) begin errors++; $display("FAIL jd_drain_ack got %b exp 1", imem_ack); end
    step();
    checks++; if (dut.state !== FETCH) begin errors++; $display("FAIL jd_state_back got %0d exp FETCH", dut.state); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL jd_pc got %h exp 100", pc_out); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL jd_dropped got %b exp 0", instr_valid); end
    n = 0;
    while (instr_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL jd_latency got %0d exp 3", n); end
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL jd_instr_pc got %h exp 100", instr_pc); end
    checks++; if (instr_out !== 32'hDEAD_0100) begin errors++; $display("FAIL jd_instr_out got %h exp DEAD0100", instr_out); end
    lat = 1;
  endtask

  task automatic test_priority();
    jump = 1'b1; jump_target = 32'h200;
    branch_taken = 1'b1; branch_target = 32'h300;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL prio_pc got %h exp 200", pc_out); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL prio_squash got %b exp 0", instr_valid); end
    step();
    checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL prio_instr_pc got %h exp 200", instr_pc); end
  endtask

  task automatic test_reset_mid();
    jump = 1'b1; jump_target = 32'h7C;
    step();
    jump = 1'b0;
    step();
    checks++; if (pc_out !== 32'h80) begin errors++; $display("FAIL rm_pc_pre got %h exp 80", pc_out); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rm_valid_pre got %b exp 1", instr_valid); end
    lat = 3;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin errors++; $display("FAIL rm_outstanding got req %b ack %b exp req 1 ack 0", imem_req, imem_ack); end
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %b exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", instr_valid); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rm_pc got %h exp 0", pc_out); end
    step();
    step();
    lat = 1;
    rst_n = 1'b1;
    #1;
    checks++; if (pc_out !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL rm_release got pc %h req %b exp pc 0 req 1", pc_out, imem_req); end
    step();
    checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL rm_restart_pc got %h exp 4", pc_out); end
    checks++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin errors++; $display("FAIL rm_restart_instr got pc %h valid %b exp pc 0 valid 1", instr_pc, instr_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_drain();
    test_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
